// File: rtl/spi_cfg_master.sv
// spi_cfg_master: host-side SPI master for the chip's configuration register bank.
// Each accepted command becomes one 16-bit frame {rw, addr[6:0], data[7:0]}, MSB first.
// Illegal addresses are answered with an error response and never reach the pads.
module spi_cfg_master #(
   parameter int CLK_DIV     = 4,
   parameter int CS_GAP      = 4,
   parameter int NUM_WR_REGS = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy,
   output logic       spi_clk,
   output logic       cs,
   output logic       pico_spi,
   input  logic       poci_spi
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [2:0] S_RESP  = 3'd6;

   // Counters count down to zero, so they load with "cycles - 1" on state entry.
   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);
   localparam logic [6:0] MAX_ADDR = 7'(NUM_WR_REGS);

   logic [2:0]  state_q, state_d;
   logic [15:0] shreg_q, shreg_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rw_q, rw_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  gap_q, gap_d;
   logic        cs_q, cs_d;
   logic        sclk_q, sclk_d;
   logic        pico_q, pico_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   // Next-state logic: frame sequencing, serial clock generation and shift/capture.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      rdata_d     = rdata_q;
      rw_d        = rw_q;
      div_d       = div_q;
      bit_d       = bit_q;
      gap_d       = gap_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      pico_d      = pico_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               shreg_d = {cmd_rw, cmd_addr, (cmd_rw ? cmd_wdata : 8'h00)};
               rw_d    = cmd_rw;
               rdata_d = 8'h00;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if ((shreg_q[14:8] == 7'd0) || (shreg_q[14:8] > MAX_ADDR)) begin
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 8'h00;
               state_d     = S_RESP;
            end else begin
               cs_d    = 1'b1;
               sclk_d  = 1'b0;
               pico_d  = shreg_q[15];
               div_d   = DIV_LOAD;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            if (div_q == 8'd0) begin
               sclk_d  = 1'b1;
               bit_d   = 4'd0;
               div_d   = DIV_LOAD;
               state_d = S_SHIFT;
            end else begin
               div_d = div_q - 8'd1;
            end
         end

         S_SHIFT: begin
            if (div_q != 8'd0) begin
               div_d = div_q - 8'd1;
            end else if (sclk_q) begin
               sclk_d  = 1'b0;
               shreg_d = {shreg_q[14:0], 1'b0};
               pico_d  = shreg_q[14];
               div_d   = DIV_LOAD;
               if (bit_q[3]) begin
                  rdata_d = {rdata_q[6:0], poci_spi};
               end
            end else if (bit_q == 4'd15) begin
               div_d   = DIV_LOAD;
               state_d = S_HOLD;
            end else begin
               bit_d  = bit_q + 4'd1;
               sclk_d = 1'b1;
               div_d  = DIV_LOAD;
            end
         end

         S_HOLD: begin
            if (div_q == 8'd0) begin
               cs_d    = 1'b0;
               pico_d  = 1'b0;
               gap_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               div_d = div_q - 8'd1;
            end
         end

         S_GAP: begin
            if (gap_q == 8'd0) begin
               rsp_err_d   = 1'b0;
               rsp_rdata_d = rw_q ? 8'h00 : rdata_q;
               state_d     = S_RESP;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset drops cs and spi_clk at once, aborting any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shreg_q     <= 16'h0000;
         rdata_q     <= 8'h00;
         rw_q        <= 1'b0;
         div_q       <= 8'd0;
         bit_q       <= 4'd0;
         gap_q       <= 8'd0;
         cs_q        <= 1'b0;
         sclk_q      <= 1'b0;
         pico_q      <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         rdata_q     <= rdata_d;
         rw_q        <= rw_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         gap_q       <= gap_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         pico_q      <= pico_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE) && !rst;
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign spi_clk   = sclk_q;
   assign cs        = cs_q;
   assign pico_spi  = pico_q;

endmodule

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- Host-side SPI master that sequences single-register accesses into the chip's SPI write/read register bank (addresses 1..NUM_WR_REGS).
- Accepts one command at a time over a valid/ready interface and serializes it as a 16-bit frame: {rw, addr[6:0]}, then data[7:0], MSB first.
- Generates spi_clk, cs and pico_spi, captures poci_spi, and returns read data with a response strobe.
- Sits between the slow-control/firmware bus and the chip pads; it is the only driver of the configuration SPI.

Parameters:
- CLK_DIV, 4, clk cycles per spi_clk half-period (legal range 2..255).
- CS_GAP, 4, minimum clk cycles cs is held low between frames (legal range 1..255).
- NUM_WR_REGS, 11, highest legal register address; address 0 and addresses above this are rejected.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_rw  input  1  1 = write, 0 = read.
- cmd_addr  input  7  register address.
- cmd_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  8  read data; 0 for writes and errors.
- rsp_err  output  1  qualified by rsp_valid; illegal address.
- busy  output  1  high in every state except IDLE.
- spi_clk  output  1  serial clock, idles low.
- cs  output  1  chip select, active-high, idles low.
- pico_spi  output  1  serial data to chip.
- poci_spi  input  1  serial data from chip.

Behaviour:
- Reset values: cmd_ready=0 while rst is high and 1 in IDLE after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, spi_clk=0, cs=0, pico_spi=0. FSM is in IDLE.
- Reset asserted mid-frame: cs and spi_clk drop asynchronously. The frame is aborted, no response is produced, and any captured data is discarded.
- States: IDLE, CHECK, SETUP, SHIFT, HOLD, GAP, RESP.
- IDLE:
  - On accept, latch the frame as shreg = {cmd_rw, cmd_addr, cmd_rw ? cmd_wdata : 8'h00}.
  - Go to CHECK.
- CHECK (1 cycle):
  - If addr==0 or addr>NUM_WR_REGS, go to RESP with err=1. cs never asserts.
  - Otherwise go to SETUP.
- SETUP (CLK_DIV cycles): cs=1, spi_clk=0, pico_spi=shreg[15].
- SHIFT: 16 spi_clk pulses, 2*CLK_DIV cycles each, bit counter 0..15.
  - spi_clk is high for the first CLK_DIV cycles of a pulse and low for the second CLK_DIV cycles.
  - At each falling edge, shreg shifts left and pico_spi presents the next bit.
  - For pulses 8..15 (data phase), poci_spi is sampled in the same cycle as the falling edge into rdata, MSB first.
  - After the falling edge of pulse 15, go to HOLD.
- HOLD (CLK_DIV cycles): cs=1, spi_clk=0. Then cs=0 and go to GAP.
- GAP (CS_GAP cycles): cs=0. Then go to RESP.
- RESP (1 cycle):
  - rsp_valid=1, rsp_err=err.
  - rsp_rdata = rdata for a successful read, otherwise 0.
  - Next state is IDLE. rsp_rdata and rsp_err hold their values until the next RESP.
- Frame timing: cs is high for exactly (2 + 32)*CLK_DIV cycles. Accept to rsp_valid latency = 1 + 34*CLK_DIV + CS_GAP + 1 cycles, which is 142 at the defaults.
- Back-to-back commands: cmd_ready re-asserts the cycle after RESP, so the cs low time between frames is ≥ CS_GAP + 2 cycles.
- Error path: accept to rsp_valid latency is 2 cycles.
- Every frame deasserts cs. The chip's instruction register clears when cs drops, so each instruction write yields exactly one pulse.
- spi_clk, cs and pico_spi are registered outputs with no combinational path from the cmd_* inputs.
- Internal counters: 8-bit divider, 4-bit bit counter, 8-bit gap counter. No wrap is permitted; counters reload on state entry.

Test Plan:
- Write addr 7'd4, data 8'h02 at defaults -> pico_spi sequence is 1,0000100,00000010. cs is high for 136 cycles with 16 spi_clk rising edges. rsp_valid arrives 142 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read addr 7'd11, bench model drives 8'h1f on poci_spi during pulses 8..15 -> first pico_spi bit is 0, the data byte sent is 8'h00, and rsp_rdata=8'h1f.
- Commands at addr 0 and addr 12 -> cs and spi_clk never toggle, rsp_valid arrives 2 cycles after accept with rsp_err=1, and busy returns to 0.
- cmd_valid held high for 3 writes -> 3 frames, each cs-low gap ≥ CS_GAP+2 cycles. cmd_ready is low throughout each frame.
- Assert rst during SHIFT pulse 5 -> cs, spi_clk and pico_spi go to 0 immediately with no rsp_valid. After release, the next command completes normally.
- CLK_DIV=2, CS_GAP=1 -> spi_clk period is 4 cycles, cs is high for 68 cycles, and accept to rsp_valid is 71 cycles.
